// File: rtl/quad_decoder_bank.sv
// quad_decoder_bank
// Multi-channel quadrature decoder for trackball/spinner inputs. Each channel
// synchronises its asynchronous A/B pair, glitch-filters it, decodes
// accepted Gray-code transitions into an up/down count at x1/x2/x4
// resolution and flags illegal (double-bit) transitions. One channel's
// count is presented on a registered output byte selected by sel.

module quad_decoder_bank #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 9,
    parameter int OUT_W    = 8,
    parameter int FILT     = 2,
    parameter int SEL_W    = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] a,
    input  logic [CHANNELS-1:0] b,
    input  logic [1:0]          res_mode,
    input  logic                clr,
    input  logic [SEL_W-1:0]    sel,
    output logic [OUT_W-1:0]    dout,
    output logic [CHANNELS-1:0] err
);

    // Filter counter must hold 0..FILT; keep at least one bit when FILT = 0.
    localparam int FCNT_W = (FILT > 0) ? $clog2(FILT + 1) : 1;
    localparam logic [FCNT_W-1:0] FILT_MAX = FCNT_W'(FILT);

    // Resolution codes; 2'd3 behaves as x4.
    localparam logic [1:0] RES_X1 = 2'd0;
    localparam logic [1:0] RES_X2 = 2'd1;

    // Upper OUT_W bits of every channel counter, for the read mux.
    logic [OUT_W-1:0] cnt_hi [CHANNELS];

    // ------------------------------------------------------------------
    // Synchroniser fill tracker. The synchroniser flops come out of reset
    // holding 0, which is not a real input sample. Priming waits until the
    // second stage holds a genuinely captured value so a channel sitting
    // at 11 (or any non-zero state) at reset release is not mistaken for a
    // 00 -> 11 move.
    // ------------------------------------------------------------------
    logic [1:0] sync_vld_q;
    logic [1:0] sync_vld_d;

    // Shift a one in behind reset release.
    always_comb begin
        sync_vld_d = {sync_vld_q[0], 1'b1};
    end

    // Fill tracker register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_vld_q <= '0;
        end else begin
            sync_vld_q <= sync_vld_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel datapath.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : ch_g
            // {A,B} pairs throughout: bit 1 = A, bit 0 = B.
            logic [1:0]        sync1_q, sync1_d;
            logic [1:0]        sync2_q, sync2_d;
            logic [1:0]        acc_q,   acc_d;
            logic [FCNT_W-1:0] fcnt_q,  fcnt_d;
            logic              primed_q, primed_d;
            logic [CNT_W-1:0]  cnt_q,   cnt_d;
            logic              err_q,   err_d;

            logic accept;
            logic step_fwd;
            logic step_rev;
            logic illegal;
            logic a_changed;
            logic a_rise;
            logic res_gate;
            logic cnt_up;
            logic cnt_dn;

            // Synchroniser chain plus filter/acceptance of a new state.
            always_comb begin
                sync1_d  = {a[gi], b[gi]};
                sync2_d  = sync1_q;
                acc_d    = acc_q;
                fcnt_d   = fcnt_q;
                primed_d = primed_q;
                accept   = 1'b0;
                if (!primed_q) begin
                    // Adopt the first real sample as the reference state;
                    // nothing is counted or flagged on this edge.
                    fcnt_d = '0;
                    if (sync_vld_q[1]) begin
                        acc_d    = sync2_q;
                        primed_d = 1'b1;
                    end
                end else if (sync2_q == acc_q) begin
                    fcnt_d = '0;
                end else if (fcnt_q == FILT_MAX) begin
                    // Input has differed for FILT+1 consecutive edges.
                    acc_d  = sync2_q;
                    fcnt_d = '0;
                    accept = 1'b1;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end

            // Classify the accepted transition old acc -> new sample.
            always_comb begin
                step_fwd  = ((acc_q == 2'b00) && (sync2_q == 2'b10)) ||
                            ((acc_q == 2'b10) && (sync2_q == 2'b11)) ||
                            ((acc_q == 2'b11) && (sync2_q == 2'b01)) ||
                            ((acc_q == 2'b01) && (sync2_q == 2'b00));
                step_rev  = ((acc_q == 2'b00) && (sync2_q == 2'b01)) ||
                            ((acc_q == 2'b01) && (sync2_q == 2'b11)) ||
                            ((acc_q == 2'b11) && (sync2_q == 2'b10)) ||
                            ((acc_q == 2'b10) && (sync2_q == 2'b00));
                illegal   = accept && ((acc_q ^ sync2_q) == 2'b11);
                a_changed = acc_q[1] ^ sync2_q[1];
                a_rise    = ~acc_q[1] & sync2_q[1];
                // x1 counts only on A rising, in either direction; x2 on
                // any A edge; x4 on every legal edge.
                case (res_mode)
                    RES_X1:  res_gate = a_rise;
                    RES_X2:  res_gate = a_changed;
                    default: res_gate = 1'b1;
                endcase
                cnt_up = accept && step_fwd && res_gate;
                cnt_dn = accept && step_rev && res_gate;
            end

            // Counter and sticky error update; clear wins over both.
            always_comb begin
                cnt_d = cnt_q;
                err_d = err_q;
                if (cnt_up) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (cnt_dn) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (illegal) begin
                    err_d = 1'b1;
                end
                if (clr) begin
                    cnt_d = '0;
                    err_d = 1'b0;
                end
            end

            // Channel state registers.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync1_q  <= '0;
                    sync2_q  <= '0;
                    acc_q    <= '0;
                    fcnt_q   <= '0;
                    primed_q <= 1'b0;
                    cnt_q    <= '0;
                    err_q    <= 1'b0;
                end else begin
                    sync1_q  <= sync1_d;
                    sync2_q  <= sync2_d;
                    acc_q    <= acc_d;
                    fcnt_q   <= fcnt_d;
                    primed_q <= primed_d;
                    cnt_q    <= cnt_d;
                    err_q    <= err_d;
                end
            end

            assign cnt_hi[gi] = cnt_q[CNT_W-1 -: OUT_W];
            assign err[gi]    = err_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read mux: registered, unpopulated select codes read as zero.
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] dout_q;
    logic [OUT_W-1:0] dout_d;

    // Select one channel's upper count bits.
    always_comb begin
        dout_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(sel) == i) begin
                dout_d = cnt_hi[i];
            end
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule
